sipo_word_receiver: RTL and testbench
=====================================

Name: sipo_word_receiver

Overview:
Serial-to-parallel receiver that consumes the single-bit stream produced by the team's PISO shift register and rebuilds DATA_WIDTH-bit words.
- A bit counter assembles each word in a shift register, then transfers it into an output holding register.
- The holding register is presented with a valid/ready handshake; overrun is detected and flagged when the consumer stalls.
- Sits directly downstream of the PISO stage on the same clock domain; clocked on the rising edge.

Parameters:
DATA_WIDTH, 16, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = first received bit lands in bit DATA_WIDTH-1; 0 = first bit lands in bit 0.

Ports:
Clk_In  input  1  clock; all state updates on rising edge.
Reset_In  input  1  synchronous, active-low reset.
Enable_In  input  1  1 = block active; 0 = all state frozen.
Frame_Start_In  input  1  realign: current bit strobe, if any, becomes bit 0 of a new word.
Shift_Data_Signal_In  input  1  bit strobe; Serial_Data_In is sampled when high.
Serial_Data_In  input  1  serial data bit.
Data_Ready_In  input  1  consumer accepts the held word when high with Data_Valid_Out.
Clear_Overrun_In  input  1  clears the sticky Overrun_Out flag.
Parallel_Data_Out  output  DATA_WIDTH  held word.
Data_Valid_Out  output  1  held word is valid.
Overrun_Out  output  1  sticky: a completed word was dropped.
Bit_Count_Out  output  $clog2(DATA_WIDTH)  bits collected in the current partial word.

Behaviour:
- Reset (Reset_In=0 at a rising edge) overrides all other inputs; a reset mid-word discards the partial word.
  - Outputs after reset: Parallel_Data_Out=0, Data_Valid_Out=0, Overrun_Out=0, Bit_Count_Out=0.
  - Internal shift register also = 0.
- Enable_In=0: every register holds its value, and all strobes, Ready and Clear are ignored.
  - Outputs keep driving their held values; there is no tri-state.
- Bit capture (Enable_In=1, Shift_Data_Signal_In=1):
  - MSB_FIRST=1: shift register <= {sreg[W-2:0], Serial_Data_In}.
  - MSB_FIRST=0: shift register <= {Serial_Data_In, sreg[W-1:1]}.
  - Bit counter increments, wrapping from W-1 to 0.
- Frame_Start_In=1 resets the counter.
  - With a strobe in the same cycle, the sampled bit is counted as bit 0, so the counter becomes 1.
  - Without a strobe, the counter becomes 0.
  - The partial word is discarded.
- Word completion is the strobe that takes the counter from W-1 to 0.
  - Completed word = the shift value including the current bit.
  - It is visible on Parallel_Data_Out with Data_Valid_Out=1 on the edge after the final strobe (1-cycle latency).
- Handshake: accept occurs when Data_Valid_Out & Data_Ready_In at a rising edge.
  - Accept with no completion in that cycle: Data_Valid_Out <= 0. Parallel_Data_Out keeps its last value.
  - Completion while not valid: load the word, set valid.
  - Completion and accept in the same cycle: load the new word, valid stays 1; no overrun.
  - Completion while valid and not accepted: the new word is dropped, the held word is unchanged, Overrun_Out <= 1.
- Overrun flag:
  - Clear_Overrun_In=1 clears it.
  - If a new overrun occurs in the same cycle as a clear, the flag ends at 1 (set wins).
- Data_Ready_In while not valid has no effect.
- Optional two-state control FSM, shown as IDLE and COLLECT on Bit_Count_Out == 0 / != 0. It is informational only; behaviour is fully defined by the counter and valid bit.

Decomposition:
- Shared package (sipo_pkg):
  - DATA_WIDTH default.
  - Counter-width function (clog2).
  - Handshake-state enum: HOLD_EMPTY, HOLD_FULL.
- One natural sub-module: sipo_holding_register.
  - Owns the output word, valid bit and overrun logic.
  - Inputs: completion pulse, word, Ready, Clear.
- The top level keeps the shift register and bit counter.

Test Plan:
1. Reset then 16 strobes of 0xA5C3 MSB-first (bit15 first), Ready=0 -> Data_Valid_Out=1 one edge after the 16th strobe, Parallel_Data_Out=0xA5C3, Bit_Count_Out=0, Overrun_Out=0.
2. Hold valid (Ready=0) and send a second word 0x1234 -> Parallel_Data_Out stays 0xA5C3, Overrun_Out=1. Then Clear_Overrun_In pulse -> Overrun_Out=0.
3. Ready asserted on the exact edge the next word 0xFFFF completes -> Parallel_Data_Out=0xFFFF, Data_Valid_Out stays 1, Overrun_Out=0.
4. Send 5 bits, then Frame_Start_In with a strobe carrying 1, then 15 more bits of 0x8001's remaining bits -> word 0x8001 received; the 5 stray bits are discarded.
5. Mid-word (Bit_Count_Out=9): drop Enable_In for 10 cycles with strobes toggling, then resume -> counter resumes at 9 and the word is assembled correctly. Then Reset_In=0 mid-word -> all outputs 0 on the next edge.
6. MSB_FIRST=0 build: send 0x0001 LSB-first -> Parallel_Data_Out=0x0001.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel word receiver: default word
// width, counter sizing helper and the holding-register handshake states.
package sipo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // Number of bits needed to count from 0 to width-1 (never less than 1).
  function automatic int count_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Holding register is either empty or presenting a word to the consumer.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/sipo_holding_register.sv
// Output holding register for the SIPO receiver. Captures each completed word,
// presents it with a valid/ready handshake and raises a sticky overrun flag
// when a completed word arrives while the consumer is still stalled.
module sipo_holding_register
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Complete_In,
  input  logic [DATA_WIDTH-1:0] Word_In,
  input  logic                  Data_Ready_In,
  input  logic                  Clear_Overrun_In,
  output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
  output logic                  Data_Valid_Out,
  output logic                  Overrun_Out
);

  hold_state_t           state_q;
  hold_state_t           state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  overrun_q;
  logic                  overrun_d;
  logic                  drop_word;

  // Handshake decisions: load, accept, or drop a completed word; set beats clear on the overrun flag.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    drop_word = 1'b0;

    case (state_q)
      HOLD_EMPTY: begin
        if (Complete_In) begin
          data_d  = Word_In;
          state_d = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        if (Complete_In) begin
          if (Data_Ready_In) begin
            data_d = Word_In;
          end else begin
            drop_word = 1'b1;
          end
        end else if (Data_Ready_In) begin
          state_d = HOLD_EMPTY;
        end
      end
    endcase

    if (Clear_Overrun_In) begin
      overrun_d = 1'b0;
    end
    if (drop_word) begin
      overrun_d = 1'b1;
    end
  end

  // State register: synchronous active-low reset, everything frozen while disabled.
  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      state_q   <= HOLD_EMPTY;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else if (Enable_In) begin
      state_q   <= state_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign Parallel_Data_Out = data_q;
  assign Data_Valid_Out    = (state_q == HOLD_FULL);
  assign Overrun_Out       = overrun_q;

endmodule

// File: rtl/sipo_word_receiver.sv
// Serial-to-parallel word receiver. Collects strobed serial bits into a shift
// register under a bit counter and hands each completed word to the holding
// register, which owns the consumer handshake and overrun detection.
module sipo_word_receiver
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          Clk_In,
  input  logic                          Reset_In,
  input  logic                          Enable_In,
  input  logic                          Frame_Start_In,
  input  logic                          Shift_Data_Signal_In,
  input  logic                          Serial_Data_In,
  input  logic                          Data_Ready_In,
  input  logic                          Clear_Overrun_In,
  output logic [DATA_WIDTH-1:0]         Parallel_Data_Out,
  output logic                          Data_Valid_Out,
  output logic                          Overrun_Out,
  output logic [$clog2(DATA_WIDTH)-1:0] Bit_Count_Out
);

  localparam int CW = count_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sreg_q;
  logic [DATA_WIDTH-1:0] shift_base;
  logic [DATA_WIDTH-1:0] shift_value;
  logic [CW-1:0]         count_q;
  logic                  word_complete;

  // Next shift value; a frame start discards the partial word so the new bit shifts into zeros.
  always_comb begin
    shift_base    = Frame_Start_In ? '0 : sreg_q;
    shift_value   = MSB_FIRST ? {shift_base[DATA_WIDTH-2:0], Serial_Data_In}
                              : {Serial_Data_In, shift_base[DATA_WIDTH-1:1]};
    word_complete = Shift_Data_Signal_In && !Frame_Start_In && (count_q == LAST_BIT);
  end

  // Shift register and bit counter; a frame start realigns so a same-cycle bit becomes bit 0.
  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      sreg_q  <= '0;
      count_q <= '0;
    end else if (Enable_In) begin
      if (Frame_Start_In) begin
        sreg_q  <= Shift_Data_Signal_In ? shift_value : '0;
        count_q <= Shift_Data_Signal_In ? CW'(1) : '0;
      end else if (Shift_Data_Signal_In) begin
        sreg_q  <= shift_value;
        count_q <= (count_q == LAST_BIT) ? '0 : count_q + CW'(1);
      end
    end
  end

  sipo_holding_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_holding_register (
    .Clk_In           (Clk_In),
    .Reset_In         (Reset_In),
    .Enable_In        (Enable_In),
    .Complete_In      (word_complete),
    .Word_In          (shift_value),
    .Data_Ready_In    (Data_Ready_In),
    .Clear_Overrun_In (Clear_Overrun_In),
    .Parallel_Data_Out(Parallel_Data_Out),
    .Data_Valid_Out   (Data_Valid_Out),
    .Overrun_Out      (Overrun_Out)
  );

  assign Bit_Count_Out = count_q;

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Self-checking bench for sipo_word_receiver: an MSB-first and an LSB-first
// instance share one directed stimulus stream and are compared every cycle
// against a bit-list reference model, plus hand-computed literal checks.
module tb_sipo_word_receiver;

  localparam int W = 16;

  logic clk;
  logic reset_in;
  logic enable;
  logic frame_start;
  logic shift_strobe;
  logic serial_data;
  logic data_ready;
  logic clear_overrun;

  logic [W-1:0] msb_data;
  logic         msb_valid;
  logic         msb_overrun;
  logic [3:0]   msb_count;
  logic [W-1:0] lsb_data;
  logic         lsb_valid;
  logic         lsb_overrun;
  logic [3:0]   lsb_count;

  int tests_run;
  int tests_failed;
  logic compare_on;

  sipo_word_receiver #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .Clk_In              (clk),
    .Reset_In            (reset_in),
    .Enable_In           (enable),
    .Frame_Start_In      (frame_start),
    .Shift_Data_Signal_In(shift_strobe),
    .Serial_Data_In      (serial_data),
    .Data_Ready_In       (data_ready),
    .Clear_Overrun_In    (clear_overrun),
    .Parallel_Data_Out   (msb_data),
    .Data_Valid_Out      (msb_valid),
    .Overrun_Out         (msb_overrun),
    .Bit_Count_Out       (msb_count)
  );

  sipo_word_receiver #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .Clk_In              (clk),
    .Reset_In            (reset_in),
    .Enable_In           (enable),
    .Frame_Start_In      (frame_start),
    .Shift_Data_Signal_In(shift_strobe),
    .Serial_Data_In      (serial_data),
    .Data_Ready_In       (data_ready),
    .Clear_Overrun_In    (clear_overrun),
    .Parallel_Data_Out   (lsb_data),
    .Data_Valid_Out      (lsb_valid),
    .Overrun_Out         (lsb_overrun),
    .Bit_Count_Out       (lsb_count)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, index 0 = MSB-first build, 1 = LSB-first build.
  int         m_count   [2];
  logic       m_bits    [2][W];
  logic [W-1:0] m_data  [2];
  logic       m_valid   [2];
  logic       m_overrun [2];
  logic       mdl_done;
  logic       mdl_drop;
  logic       mdl_accept;
  logic [W-1:0] mdl_word;

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_count[m]   = 0;
      m_data[m]    = '0;
      m_valid[m]   = 1'b0;
      m_overrun[m] = 1'b0;
      for (int i = 0; i < W; i++) m_bits[m][i] = 1'b0;
    end
  end

  // Model: keep the list of received bits, pack it by bit order on completion.
  always @(posedge clk) begin
    if (!reset_in) begin
      for (int m = 0; m < 2; m++) begin
        m_count[m]   = 0;
        m_data[m]    = '0;
        m_valid[m]   = 1'b0;
        m_overrun[m] = 1'b0;
      end
    end else if (enable) begin
      for (int m = 0; m < 2; m++) begin
        mdl_done = 1'b0;
        mdl_drop = 1'b0;
        mdl_word = '0;
        if (frame_start) begin
          if (shift_strobe) begin
            m_bits[m][0] = serial_data;
            m_count[m]   = 1;
          end else begin
            m_count[m] = 0;
          end
        end else if (shift_strobe) begin
          m_bits[m][m_count[m]] = serial_data;
          if (m_count[m] == W - 1) begin
            mdl_done   = 1'b1;
            m_count[m] = 0;
            for (int i = 0; i < W; i++) begin
              if (m == 0) mdl_word[W-1-i] = m_bits[m][i];
              else        mdl_word[i]     = m_bits[m][i];
            end
          end else begin
            m_count[m] = m_count[m] + 1;
          end
        end
        mdl_accept = m_valid[m] && data_ready;
        if (mdl_done) begin
          if (!m_valid[m] || mdl_accept) begin
            m_data[m]  = mdl_word;
            m_valid[m] = 1'b1;
          end else begin
            mdl_drop = 1'b1;
          end
        end else if (mdl_accept) begin
          m_valid[m] = 1'b0;
        end
        if (clear_overrun) m_overrun[m] = 1'b0;
        if (mdl_drop)      m_overrun[m] = 1'b1;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (compare_on) begin
      check_output("msb_data",    32'(msb_data),    32'(m_data[0]));
      check_output("msb_valid",   32'(msb_valid),   32'(m_valid[0]));
      check_output("msb_overrun", 32'(msb_overrun), 32'(m_overrun[0]));
      check_output("msb_count",   32'(msb_count),   32'(m_count[0]));
      check_output("lsb_data",    32'(lsb_data),    32'(m_data[1]));
      check_output("lsb_valid",   32'(lsb_valid),   32'(m_valid[1]));
      check_output("lsb_overrun", 32'(lsb_overrun), 32'(m_overrun[1]));
      check_output("lsb_count",   32'(lsb_count),   32'(m_count[1]));
    end
  end

  task automatic apply_stimulus(input logic en, input logic fs, input logic st,
                                input logic sd, input logic rdy, input logic clr);
    enable        = en;
    frame_start   = fs;
    shift_strobe  = st;
    serial_data   = sd;
    data_ready    = rdy;
    clear_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  // Strobe bits value[first_bit] down to value[last_bit], one per cycle.
  task automatic send_msb(input logic [W-1:0] value, input int first_bit, input int last_bit,
                          input logic rdy_last, input logic clr_last);
    for (int i = first_bit; i >= last_bit; i--) begin
      apply_stimulus(1'b1, 1'b0, 1'b1, value[i],
                     (i == last_bit) ? rdy_last : 1'b0,
                     (i == last_bit) ? clr_last : 1'b0);
    end
  endtask

  // Strobe all bits of value starting with bit 0.
  task automatic send_lsb(input logic [W-1:0] value);
    for (int i = 0; i < W; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b1, value[i], 1'b0, 1'b0);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    compare_on    = 1'b0;
    reset_in      = 1'b0;
    enable        = 1'b0;
    frame_start   = 1'b0;
    shift_strobe  = 1'b0;
    serial_data   = 1'b0;
    data_ready    = 1'b0;
    clear_overrun = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    compare_on = 1'b1;
    check_output("reset_msb_data",    32'(msb_data),    32'h0);
    check_output("reset_msb_valid",   32'(msb_valid),   32'h0);
    check_output("reset_msb_overrun", 32'(msb_overrun), 32'h0);
    check_output("reset_msb_count",   32'(msb_count),   32'h0);
    check_output("reset_lsb_data",    32'(lsb_data),    32'h0);
    check_output("reset_lsb_valid",   32'(lsb_valid),   32'h0);
    reset_in = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // First word, consumer stalled.
    send_msb(16'hA5C3, 15, 0, 1'b0, 1'b0);
    check_output("t1_data",    32'(msb_data),    32'hA5C3);
    check_output("t1_valid",   32'(msb_valid),   32'h1);
    check_output("t1_count",   32'(msb_count),   32'h0);
    check_output("t1_overrun", 32'(msb_overrun), 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Second word while still stalled -> dropped, overrun raised, then cleared.
    send_msb(16'h1234, 15, 0, 1'b0, 1'b0);
    check_output("t2_data_kept", 32'(msb_data),    32'hA5C3);
    check_output("t2_overrun",   32'(msb_overrun), 32'h1);
    check_output("t2_valid",     32'(msb_valid),   32'h1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("t2_cleared",   32'(msb_overrun), 32'h0);

    // Accept on the completing edge: new word replaces old, no overrun.
    send_msb(16'hFFFF, 15, 0, 1'b1, 1'b0);
    check_output("t3_data",    32'(msb_data),    32'hFFFF);
    check_output("t3_valid",   32'(msb_valid),   32'h1);
    check_output("t3_overrun", 32'(msb_overrun), 32'h0);

    // Accept alone drops valid but keeps the word.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("t4_accept_valid", 32'(msb_valid), 32'h0);
    check_output("t4_accept_data",  32'(msb_data),  32'hFFFF);

    // Five stray bits, then realign with a strobed frame start.
    send_msb(16'hB000, 15, 11, 1'b0, 1'b0);
    check_output("t4_stray_count", 32'(msb_count), 32'd5);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_output("t4_realign_count", 32'(msb_count), 32'd1);
    send_msb(16'h8001, 14, 0, 1'b0, 1'b0);
    check_output("t4_data",  32'(msb_data),  32'h8001);
    check_output("t4_valid", 32'(msb_valid), 32'h1);

    // Freeze mid-word with every control toggling, then resume.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_msb(16'h5A3C, 15, 7, 1'b0, 1'b0);
    check_output("t5_count_before", 32'(msb_count), 32'd9);
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b0, (k == 3), k[0], 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    check_output("t5_count_frozen", 32'(msb_count), 32'd9);
    check_output("t5_valid_frozen", 32'(msb_valid), 32'h0);
    send_msb(16'h5A3C, 6, 0, 1'b0, 1'b0);
    check_output("t5_data",  32'(msb_data),  32'h5A3C);
    check_output("t5_valid", 32'(msb_valid), 32'h1);

    // Reset in the middle of a word.
    send_msb(16'hE000, 15, 13, 1'b0, 1'b0);
    reset_in = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_output("t5_rst_data",    32'(msb_data),    32'h0);
    check_output("t5_rst_valid",   32'(msb_valid),   32'h0);
    check_output("t5_rst_overrun", 32'(msb_overrun), 32'h0);
    check_output("t5_rst_count",   32'(msb_count),   32'h0);
    reset_in = 1'b1;

    // LSB-first word: the LSB build sees 0x0001, the MSB build the reverse.
    send_lsb(16'h0001);
    check_output("t6_lsb_data",  32'(lsb_data),  32'h0001);
    check_output("t6_lsb_valid", 32'(lsb_valid), 32'h1);
    check_output("t6_msb_data",  32'(msb_data),  32'h8000);

    // Overrun and clear in the same cycle: set wins.
    send_msb(16'hABCD, 15, 0, 1'b0, 1'b1);
    check_output("t6_set_wins",   32'(lsb_overrun), 32'h1);
    check_output("t6_lsb_kept",   32'(lsb_data),    32'h0001);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    compare_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
